// File: rtl/operand_tf_lane_seq.sv
// Control sequencer for one operand-transformer lane: accepts an operand, steps the lane
// through even/odd passes plus optional feedback re-scale passes, then holds results for the consumer.
module operand_tf_lane_seq #(
    parameter int unsigned MAX_FB_PASSES = 3,
    parameter int unsigned FB_CNT_W      = 2,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                abort,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [FB_CNT_W-1:0] in_fb_passes,
    output logic                lane_load_input,
    output logic                lane_iter_sel,
    output logic                lane_feedback_sel,
    output logic                lane_we_result,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic [FB_CNT_W-1:0] pass_idx,
    output logic [CNT_W-1:0]    ops_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVEN = 2'd1,
        S_ODD  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [FB_CNT_W-1:0] LP_MAX_FB = FB_CNT_W'(MAX_FB_PASSES);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [FB_CNT_W-1:0]   r_fb_target;
    logic [FB_CNT_W-1:0]   w_fb_target_nxt;
    logic [FB_CNT_W-1:0]   r_pass_idx;
    logic [FB_CNT_W-1:0]   w_pass_idx_nxt;
    logic [CNT_W-1:0]      r_ops_done;
    logic [CNT_W-1:0]      w_ops_done_nxt;
    logic [FB_CNT_W-1:0]   w_fb_clamped;
    logic                  w_flush;

    assign w_fb_clamped = (in_fb_passes > LP_MAX_FB) ? LP_MAX_FB : in_fb_passes;
    assign w_flush      = rst || abort;
    assign pass_idx     = r_pass_idx;
    assign ops_done     = r_ops_done;

    // Next-state and lane control decode; flush forces all handshake and lane pins low.
    always_comb begin
        w_state_nxt       = r_state;
        w_fb_target_nxt   = r_fb_target;
        w_pass_idx_nxt    = r_pass_idx;
        w_ops_done_nxt    = r_ops_done;
        in_ready          = 1'b0;
        lane_load_input   = 1'b0;
        lane_iter_sel     = 1'b0;
        lane_feedback_sel = 1'b0;
        lane_we_result    = 1'b0;
        out_valid         = 1'b0;
        busy              = (r_state != S_IDLE) && !rst;

        if (w_flush) begin
            w_state_nxt     = S_IDLE;
            w_pass_idx_nxt  = '0;
            w_fb_target_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        lane_load_input = 1'b1;
                        w_fb_target_nxt = w_fb_clamped;
                        w_pass_idx_nxt  = '0;
                        w_state_nxt     = S_EVEN;
                    end
                end
                S_EVEN: begin
                    lane_we_result    = 1'b1;
                    lane_feedback_sel = (r_pass_idx != '0);
                    w_state_nxt       = S_ODD;
                end
                S_ODD: begin
                    lane_iter_sel     = 1'b1;
                    lane_we_result    = 1'b1;
                    lane_feedback_sel = (r_pass_idx != '0);
                    if (r_pass_idx == r_fb_target) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_pass_idx_nxt = r_pass_idx + FB_CNT_W'(1);
                        w_state_nxt    = S_EVEN;
                    end
                end
                S_DONE: begin
                    out_valid = 1'b1;
                    in_ready  = out_ready;
                    if (out_ready) begin
                        w_ops_done_nxt = r_ops_done + CNT_W'(1);
                        if (in_valid) begin
                            // Consume and accept together: no IDLE bubble between operands.
                            lane_load_input = 1'b1;
                            w_fb_target_nxt = w_fb_clamped;
                            w_pass_idx_nxt  = '0;
                            w_state_nxt     = S_EVEN;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_fb_target <= '0;
            r_pass_idx  <= '0;
            r_ops_done  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_fb_target <= w_fb_target_nxt;
            r_pass_idx  <= w_pass_idx_nxt;
            r_ops_done  <= w_ops_done_nxt;
        end
    end

endmodule
